// File: rtl/port_bridge_pkg.sv
// Shared port-bridge definitions: buffer-window layout, window command bundle and the
// system port-id map mirrored by the firmware headers.
package port_bridge_pkg;

    localparam logic [1:0] WIN_RDATA = 2'd0;
    localparam logic [1:0] WIN_RPTR  = 2'd1;
    localparam logic [1:0] WIN_WPTR  = 2'd2;
    localparam logic [1:0] WIN_WDATA = 2'd3;

    localparam logic [7:0] PORT_GPIO_LED  = 8'd6;
    localparam logic [7:0] PORT_RF_SYNTH  = 8'd12;
    localparam logic [7:0] PORT_RF_MODE   = 8'd31;
    localparam logic [7:0] PORT_ETH_TX_GO = 8'd34;
    localparam logic [7:0] PORT_BUF_BASE  = 8'd48;

    typedef struct packed {
        logic rptr_ld;
        logic wptr_ld;
        logic wdata_wr;
    } win_cmd_t;

    function automatic win_cmd_t win_cmd_decode(input logic wr, input logic hit, input logic [1:0] sel);
        win_cmd_t cmd;
        cmd.rptr_ld  = wr & hit & (sel == WIN_RPTR);
        cmd.wptr_ld  = wr & hit & (sel == WIN_WPTR);
        cmd.wdata_wr = wr & hit & (sel == WIN_WDATA);
        return cmd;
    endfunction

endpackage

// File: rtl/port_bridge_regs_buf_window_ctl.sv
// Buffer-window pointer control: read/write pointers into the packet RAM, write-enable pulse,
// and the post-read auto-increment taken on the falling edge of an RDATA read strobe.
module buf_window_ctl
    import port_bridge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BUF_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  win_cmd_t          cmd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read_strobe,
    input  logic              rdata_hit,
    output logic [BUF_AW-1:0] buf_raddr,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              buf_we
);

    localparam logic [BUF_AW-1:0] PTR_ONE = BUF_AW'(1);

    logic              rd_strobe_r;
    logic              rd_fall_s;
    logic [BUF_AW-1:0] ptr_load_s;

    assign ptr_load_s = wr_data[BUF_AW-1:0];
    // The RDATA qualifier is remembered so a pointer write may share the falling-edge cycle.
    assign rd_fall_s  = rd_strobe_r & ~read_strobe;

    // Track whether the previous cycle carried a read strobe aimed at RDATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_strobe_r <= 1'b0;
        end else begin
            rd_strobe_r <= read_strobe & rdata_hit;
        end
    end

    // Read pointer: an explicit load beats the post-read increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_raddr <= {BUF_AW{1'b0}};
        end else if (cmd.rptr_ld) begin
            buf_raddr <= ptr_load_s;
        end else if (rd_fall_s) begin
            buf_raddr <= buf_raddr + PTR_ONE;
        end
    end

    // Write pointer: advances the cycle after each RAM write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_waddr <= {BUF_AW{1'b0}};
        end else if (cmd.wptr_ld) begin
            buf_waddr <= ptr_load_s;
        end else if (buf_we) begin
            buf_waddr <= buf_waddr + PTR_ONE;
        end
    end

    // Single-cycle RAM write strobe with its captured data byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_we    <= 1'b0;
            buf_wdata <= {DATA_W{1'b0}};
        end else begin
            buf_we <= cmd.wdata_wr;
            if (cmd.wdata_wr) begin
                buf_wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/port_bridge_regs.sv
// Housekeeping port bank between the CPU port bus and board logic: output register bank with
// per-port reset values and pulse registers, registered read mux, and the packet-buffer window.
module port_bridge_regs
    import port_bridge_pkg::*;
#(
    parameter int                      DATA_W     = 8,
    parameter int                      ADDR_W     = 8,
    parameter int                      N_OUT      = 48,
    parameter int                      N_IN       = 64,
    parameter logic [N_OUT-1:0]        OUT_MASK   = {N_OUT{1'b1}},
    parameter logic [N_IN-1:0]         IN_MASK    = {N_IN{1'b1}},
    parameter logic [N_OUT-1:0]        PULSE_MASK = {N_OUT{1'b0}},
    parameter logic [N_OUT*DATA_W-1:0] OUT_RESET  = {(N_OUT*DATA_W){1'b0}},
    parameter logic [ADDR_W-1:0]       BUF_BASE   = ADDR_W'(48),
    parameter int                      BUF_AW     = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       port_id,
    input  logic                    write_strobe,
    input  logic [DATA_W-1:0]       out_port,
    input  logic                    read_strobe,
    output logic [DATA_W-1:0]       in_port,
    output logic [N_OUT*DATA_W-1:0] out_regs,
    input  logic [N_IN*DATA_W-1:0]  in_ports,
    output logic [BUF_AW-1:0]       buf_raddr,
    input  logic [DATA_W-1:0]       buf_rdata,
    output logic [BUF_AW-1:0]       buf_waddr,
    output logic [DATA_W-1:0]       buf_wdata,
    output logic                    buf_we
);

    logic [ADDR_W-1:0] win_off_s;
    logic              win_hit_s;
    logic [1:0]        win_sel_s;
    win_cmd_t          win_cmd_s;
    logic              rdata_hit_s;
    logic [DATA_W-1:0] in_vals_s [N_IN];
    logic [DATA_W-1:0] in_sel_s;
    logic [DATA_W-1:0] rd_data_s;

    // Unsigned offset from the window base: ids below the base wrap far above 3.
    assign win_off_s   = port_id - BUF_BASE;
    assign win_hit_s   = (win_off_s[ADDR_W-1:2] == {(ADDR_W-2){1'b0}});
    assign win_sel_s   = win_off_s[1:0];
    assign win_cmd_s   = win_cmd_decode(write_strobe, win_hit_s, win_sel_s);
    assign rdata_hit_s = win_hit_s & (win_sel_s == WIN_RDATA);

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        if (OUT_MASK[i]) begin : g_impl
            logic [DATA_W-1:0] reg_r;
            logic              wr_hit_s;

            assign wr_hit_s = write_strobe & ~win_hit_s & (port_id == ADDR_W'(i));

            // Output register; pulse ports fall back to their reset slice unless rewritten.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_r <= OUT_RESET[i*DATA_W +: DATA_W];
                end else if (wr_hit_s) begin
                    reg_r <= out_port;
                end else if (PULSE_MASK[i]) begin
                    reg_r <= OUT_RESET[i*DATA_W +: DATA_W];
                end
            end

            assign out_regs[i*DATA_W +: DATA_W] = reg_r;
        end else begin : g_tied
            assign out_regs[i*DATA_W +: DATA_W] = OUT_RESET[i*DATA_W +: DATA_W];
        end
    end

    for (genvar j = 0; j < N_IN; j++) begin : g_in
        assign in_vals_s[j] = IN_MASK[j] ? in_ports[j*DATA_W +: DATA_W] : {DATA_W{1'b1}};
    end

    // Input-port select; ids beyond the input range read as all-ones.
    always_comb begin
        in_sel_s = {DATA_W{1'b1}};
        for (int k = 0; k < N_IN; k++) begin
            in_sel_s = (port_id == ADDR_W'(k)) ? in_vals_s[k] : in_sel_s;
        end
    end

    // Read-data source: the buffer window shadows any register or input at the same id.
    always_comb begin
        rd_data_s = {DATA_W{1'b1}};
        if (win_hit_s) begin
            case (win_sel_s)
                WIN_RDATA: rd_data_s = buf_rdata;
                WIN_RPTR:  rd_data_s = DATA_W'(buf_raddr);
                WIN_WPTR:  rd_data_s = DATA_W'(buf_waddr);
                WIN_WDATA: rd_data_s = {DATA_W{1'b0}};
                default:   rd_data_s = {DATA_W{1'b1}};
            endcase
        end else begin
            rd_data_s = in_sel_s;
        end
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_port <= {DATA_W{1'b1}};
        end else begin
            in_port <= rd_data_s;
        end
    end

    buf_window_ctl #(
        .DATA_W (DATA_W),
        .BUF_AW (BUF_AW)
    ) u_buf_window_ctl (
        .clk         (clk),
        .reset       (reset),
        .cmd         (win_cmd_s),
        .wr_data     (out_port),
        .read_strobe (read_strobe),
        .rdata_hit   (rdata_hit_s),
        .buf_raddr   (buf_raddr),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .buf_we      (buf_we)
    );

endmodule
